// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alu_pkg
// Description : Opcode constants, controller state encoding and the
//               operand-rejection rule shared by the ALU sharing block.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_ROL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_NOR  = 4'd11;
  localparam logic [3:0] OP_NAND = 4'd12;
  localparam logic [3:0] OP_XNOR = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Divide by zero and the two unassigned opcodes are refused by the controller.
  function automatic logic op_rejected(input logic [3:0] sel, input logic [3:0] b);
    return ((sel == OP_DIV) && (b == 4'd0)) || (sel == 4'hE) || (sel == 4'hF);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface   : alu_share_arbiter_if
// Description : Request (per-requester valid/ready with packed operand
//               slices) and shared tagged response channel.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_share_arbiter_if #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_sel;
  logic [4*NREQ-1:0] req_a;
  logic [4*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_data;
  logic              rsp_carry;
  logic              rsp_err;

  // Requester / response-consumer side.
  modport master (
    output req_valid, req_sel, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_sel, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/fourbitexampleALU.sv
`default_nettype none
// ============================================================================
// Module      : fourbitexampleALU
// Description : Combinational 4-bit ALU, 8-bit zero-extended result and
//               carry-out of the unsigned 4-bit sum of A and B.
// Revision    : 1.0 - initial release
// ============================================================================
module fourbitexampleALU
  import alu_pkg::*;
(
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] ALU_Sel,
  output logic [7:0] ALU_Out,
  output logic       CarryOut
);

  logic [4:0] w_sum;

  assign w_sum    = {1'b0, A} + {1'b0, B};
  assign CarryOut = w_sum[4];

  // Result select; arithmetic is done in 8 bits so sums and products do not wrap.
  always_comb begin
    ALU_Out = 8'h00;
    case (ALU_Sel)
      OP_ADD:  ALU_Out = {4'h0, A} + {4'h0, B};
      OP_SUB:  ALU_Out = {4'h0, A} - {4'h0, B};
      OP_MUL:  ALU_Out = {4'h0, A} * {4'h0, B};
      OP_DIV:  ALU_Out = (B == 4'd0) ? 8'h00 : {4'h0, A / B};
      OP_SHL:  ALU_Out = {3'b000, A, 1'b0};
      OP_SHR:  ALU_Out = {5'b00000, A[3:1]};
      OP_ROL:  ALU_Out = {4'h0, A[2:0], A[3]};
      OP_ROR:  ALU_Out = {4'h0, A[0], A[3:1]};
      OP_AND:  ALU_Out = {4'h0, A & B};
      OP_OR:   ALU_Out = {4'h0, A | B};
      OP_XOR:  ALU_Out = {4'h0, A ^ B};
      OP_NOR:  ALU_Out = {4'h0, ~(A | B)};
      OP_NAND: ALU_Out = {4'h0, ~(A & B)};
      OP_XNOR: ALU_Out = {4'h0, ~(A ^ B)};
      4'hE:    ALU_Out = (A > B)  ? 8'h01 : 8'h00;
      4'hF:    ALU_Out = (A == B) ? 8'h01 : 8'h00;
      default: ALU_Out = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin search of the request vector starting at the
//               pointer, ascending with wrap; one-hot or zero grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o
);

  int             w_sum;
  logic [IDW-1:0] w_idx;
  logic           w_found;

  // Walk NREQ slots from the pointer; the first asserted request wins.
  always_comb begin
    gnt_o   = '0;
    w_found = 1'b0;
    w_sum   = 0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = int'(ptr_i) + k;
      if (w_sum >= NREQ) w_sum = w_sum - NREQ;
      w_idx = IDW'(w_sum);
      if (en_i && !w_found && req_i[w_idx]) begin
        gnt_o[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Shares one fourbitexampleALU between NREQ requesters with
//               round-robin grant, one op outstanding, and a tagged
//               response channel with backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1,
  parameter int CNTW = 16
) (
  input  logic                clk,
  input  logic                rst,
  alu_share_arbiter_if.slave  bus,
  output logic                busy,
  output logic [CNTW-1:0]     op_count
);

  state_t          state_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [IDW-1:0]  rr_ptr_d;
  logic [3:0]      op_sel_q;
  logic [3:0]      op_a_q;
  logic [3:0]      op_b_q;
  logic [IDW-1:0]  op_id_q;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [7:0]      rsp_data_q;
  logic            rsp_carry_q;
  logic            rsp_err_q;
  logic [CNTW-1:0] op_count_q;
  logic [CNTW-1:0] op_count_d;

  logic [NREQ-1:0] w_gnt;
  logic            w_xfer;
  logic [IDW-1:0]  w_win_id;
  logic [3:0]      w_win_sel;
  logic [3:0]      w_win_a;
  logic [3:0]      w_win_b;
  logic [7:0]      w_alu_out;
  logic            w_alu_carry;
  logic            w_reject;

  // Grants are only offered while idle and out of reset.
  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req_i (bus.req_valid),
    .ptr_i (rr_ptr_q),
    .en_i  ((state_q == ST_IDLE) && !rst),
    .gnt_o (w_gnt)
  );

  assign bus.req_ready = w_gnt;
  assign w_xfer        = |(bus.req_valid & w_gnt);

  // Encode the one-hot grant and pick the winner's operand slices.
  always_comb begin
    w_win_id  = '0;
    w_win_sel = 4'h0;
    w_win_a   = 4'h0;
    w_win_b   = 4'h0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_win_id  = IDW'(i);
        w_win_sel = bus.req_sel[4*i +: 4];
        w_win_a   = bus.req_a[4*i +: 4];
        w_win_b   = bus.req_b[4*i +: 4];
      end
    end
  end

  assign rr_ptr_d   = (w_win_id == IDW'(NREQ - 1)) ? '0 : w_win_id + 1'b1;
  assign op_count_d = op_count_q + 1'b1;

  fourbitexampleALU u_alu (
    .A        (op_a_q),
    .B        (op_b_q),
    .ALU_Sel  (op_sel_q),
    .ALU_Out  (w_alu_out),
    .CarryOut (w_alu_carry)
  );

  assign w_reject = op_rejected(op_sel_q, op_b_q);

  // Controller: accept one request, capture the ALU result, hold it until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      op_sel_q    <= 4'h0;
      op_a_q      <= 4'h0;
      op_b_q      <= 4'h0;
      op_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= 8'h00;
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      op_count_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_xfer) begin
            op_sel_q <= w_win_sel;
            op_a_q   <= w_win_a;
            op_b_q   <= w_win_b;
            op_id_q  <= w_win_id;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_valid_q <= 1'b1;
          rsp_id_q    <= op_id_q;
          rsp_data_q  <= w_reject ? 8'h00 : w_alu_out;
          rsp_carry_q <= w_reject ? 1'b0  : w_alu_carry;
          rsp_err_q   <= w_reject;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_d;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (state_q != ST_IDLE);
  assign op_count      = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Self-checking bench for alu_share_arbiter with a response
//               scoreboard fed at request acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 2;
  localparam int IDW  = 1;
  localparam int CNTW = 16;

  typedef struct packed {
    logic [3:0] sel;
    logic [3:0] a;
    logic [3:0] b;
  } op_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [7:0]     data;
    logic           carry;
    logic           err;
  } rsp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            busy;
  logic [CNTW-1:0] op_count;

  alu_share_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  alu_share_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW),
    .CNTW (CNTW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  op_t             q0[$];
  op_t             q1[$];
  rsp_t            sb[$];
  int              grants[$];
  logic [NREQ-1:0] acc;
  int              tests = 0;
  int              fails = 0;

  // Reference ALU + rejection rule, written from the opcode table.
  function automatic rsp_t model(input logic [IDW-1:0] id, input op_t op);
    rsp_t r;
    int   a, b, d;
    a = op.a;
    b = op.b;
    d = 0;
    r.id    = id;
    r.err   = ((op.sel == 4'd3) && (b == 0)) || (op.sel >= 4'd14);
    r.carry = 1'b0;
    r.data  = 8'h00;
    if (!r.err) begin
      r.carry = ((a + b) > 15);
      case (op.sel)
        4'd0:  d = a + b;
        4'd1:  d = a - b;
        4'd2:  d = a * b;
        4'd3:  d = a / b;
        4'd4:  d = a * 2;
        4'd5:  d = a / 2;
        4'd6:  d = ((a << 1) | (a >> 3)) & 15;
        4'd7:  d = ((a >> 1) | ((a & 1) << 3)) & 15;
        4'd8:  d = a & b;
        4'd9:  d = a | b;
        4'd10: d = a ^ b;
        4'd11: d = (~(a | b)) & 15;
        4'd12: d = (~(a & b)) & 15;
        4'd13: d = (~(a ^ b)) & 15;
        default: d = 0;
      endcase
      r.data = d[7:0];
    end
    return r;
  endfunction

  // Present the head of each requester queue.
  task automatic drive_queues();
    bus.req_valid[0] = (q0.size() != 0);
    if (q0.size() != 0) begin
      bus.req_sel[3:0] = q0[0].sel;
      bus.req_a[3:0]   = q0[0].a;
      bus.req_b[3:0]   = q0[0].b;
    end
    bus.req_valid[1] = (q1.size() != 0);
    if (q1.size() != 0) begin
      bus.req_sel[7:4] = q1[0].sel;
      bus.req_a[7:4]   = q1[0].a;
      bus.req_b[7:4]   = q1[0].b;
    end
  endtask

  // One clock: sample handshakes at negedge, return 1 unit after posedge.
  task automatic tick();
    rsp_t exp_r, got_r;
    op_t  o;
    acc = '0;
    @(negedge clk);
    if (!rst) begin
      tests++;
      if (!$onehot0(bus.req_ready)) begin
        fails++;
        $display("FAIL ready_onehot got=%b required one-hot or zero", bus.req_ready);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          o.sel = bus.req_sel[4*i +: 4];
          o.a   = bus.req_a[4*i +: 4];
          o.b   = bus.req_b[4*i +: 4];
          sb.push_back(model(IDW'(i), o));
          grants.push_back(i);
          acc[i] = 1'b1;
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL rsp_unexpected got id=%0d data=%02h, required no response", bus.rsp_id, bus.rsp_data);
        end else begin
          exp_r       = sb.pop_front();
          got_r.id    = bus.rsp_id;
          got_r.data  = bus.rsp_data;
          got_r.carry = bus.rsp_carry;
          got_r.err   = bus.rsp_err;
          if (got_r !== exp_r) begin
            fails++;
            $display("FAIL rsp got id=%0d data=%02h carry=%0b err=%0b, required id=%0d data=%02h carry=%0b err=%0b",
                     got_r.id, got_r.data, got_r.carry, got_r.err, exp_r.id, exp_r.data, exp_r.carry, exp_r.err);
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pop_accepted();
    if (acc[0]) void'(q0.pop_front());
    if (acc[1]) void'(q1.pop_front());
  endtask

  // Run queued ops to completion; cycles reports clocks used.
  task automatic run_queues(input int budget, input bit rand_rdy, output int cycles);
    bit done;
    done   = 1'b0;
    cycles = 0;
    for (int c = 0; c < budget; c++) begin
      bus.rsp_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      drive_queues();
      tick();
      pop_accepted();
      cycles++;
      if (q0.size() == 0 && q1.size() == 0 && sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL run_timeout pending q0=%0d q1=%0d sb=%0d, required 0", q0.size(), q1.size(), sb.size());
    end
  endtask

  task automatic wait_rsp(input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      drive_queues();
      tick();
      pop_accepted();
      if (bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL wait_rsp_timeout rsp_valid=%0b, required 1", bus.rsp_valid);
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    grants.delete();
    q0.delete();
    q1.delete();
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.req_valid = '1;
    bus.req_sel   = '0;
    bus.req_a     = 8'h35;
    bus.req_b     = 8'h12;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 1'b0 || op_count !== '0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_state got ready=%b rsp_valid=%0b cnt=%0d busy=%0b, required 00/0/0/0",
               bus.req_ready, bus.rsp_valid, op_count, busy);
    end
    tests++;
    if (bus.rsp_id !== '0 || bus.rsp_data !== 8'h00 || bus.rsp_carry !== 1'b0 || bus.rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_rsp got id=%0d data=%02h carry=%0b err=%0b, required all 0",
               bus.rsp_id, bus.rsp_data, bus.rsp_carry, bus.rsp_err);
    end
    bus.req_valid = '0;
    rst           = 1'b0;
    // Reset while a response waits: it must vanish without counting.
    bus.rsp_ready = 1'b0;
    q0.push_back('{sel: 4'd0, a: 4'd1, b: 4'd2});
    wait_rsp(10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== '0) begin
      fails++;
      $display("FAIL reset_in_resp got rsp_valid=%0b busy=%0b cnt=%0d, required 0/0/0", bus.rsp_valid, busy, op_count);
    end
    do_reset();
  endtask

  task automatic test_single();
    bus.rsp_ready = 1'b1;
    q0.push_back('{sel: 4'd0, a: 4'd9, b: 4'd8});
    drive_queues();
    #1;
    tests++;
    if (bus.req_ready !== 2'b01) begin
      fails++;
      $display("FAIL single_ready got=%b required 01", bus.req_ready);
    end
    tick();
    tests++;
    if (acc !== 2'b01) begin
      fails++;
      $display("FAIL single_accept got=%b required 01", acc);
    end
    pop_accepted();
    drive_queues();
    tests++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_exec got rsp_valid=%0b busy=%0b, required 0/1", bus.rsp_valid, busy);
    end
    tick();
    tests++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_data !== 8'h11 ||
        bus.rsp_carry !== 1'b1 || bus.rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL single_rsp got v=%0b id=%0d data=%02h carry=%0b err=%0b, required 1/0/11/1/0",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_carry, bus.rsp_err);
    end
    tick();
    tests++;
    if (op_count !== 16'd1 || bus.rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_done got cnt=%0d rsp_valid=%0b, required 1/0", op_count, bus.rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    int cyc;
    int exp_g;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      q0.push_back('{sel: 4'd0, a: 4'(k + 1), b: 4'd3});
      q1.push_back('{sel: 4'd2, a: 4'(k + 2), b: 4'd5});
    end
    run_queues(100, 1'b0, cyc);
    tests++;
    if (grants.size() != 6) begin
      fails++;
      $display("FAIL rr_grant_count got=%0d required 6", grants.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        exp_g = k % 2;
        tests++;
        if (grants[k] !== exp_g) begin
          fails++;
          $display("FAIL rr_order[%0d] got=%0d required %0d", k, grants[k], exp_g);
        end
      end
    end
    tests++;
    if (op_count !== 16'd6) begin
      fails++;
      $display("FAIL rr_op_count got=%0d required 6", op_count);
    end
    tests++;
    if (cyc != 18) begin
      fails++;
      $display("FAIL rr_throughput got=%0d cycles required 18", cyc);
    end
  endtask

  task automatic test_backpressure();
    logic [CNTW-1:0] cnt0;
    bus.rsp_ready = 1'b0;
    q1.push_back('{sel: 4'd2, a: 4'd15, b: 4'd15});
    wait_rsp(10);
    bus.req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      tick();
      tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'hE1 || bus.rsp_id !== 1'b1 || bus.req_ready !== 2'b00) begin
        fails++;
        $display("FAIL bp_hold[%0d] got v=%0b data=%02h id=%0d ready=%b, required 1/E1/1/00",
                 k, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req_ready);
      end
    end
    bus.req_valid = '0;
    cnt0          = op_count;
    bus.rsp_ready = 1'b1;
    tick();
    tests++;
    if (op_count !== cnt0 + 1'b1 || sb.size() != 0) begin
      fails++;
      $display("FAIL bp_release got cnt=%0d sb=%0d, required %0d/0", op_count, sb.size(), cnt0 + 1'b1);
    end
  endtask

  task automatic test_errors();
    int cyc;
    logic [CNTW-1:0] cnt0;
    cnt0 = op_count;
    q0.push_back('{sel: 4'd3,  a: 4'd7,  b: 4'd0});
    q0.push_back('{sel: 4'hE,  a: 4'd5,  b: 4'd5});
    q0.push_back('{sel: 4'd3,  a: 4'd13, b: 4'd4});
    q1.push_back('{sel: 4'hF,  a: 4'd9,  b: 4'd9});
    q1.push_back('{sel: 4'd3,  a: 4'd0,  b: 4'd0});
    run_queues(100, 1'b0, cyc);
    tests++;
    if (op_count !== cnt0 + 16'd5) begin
      fails++;
      $display("FAIL err_op_count got=%0d required %0d", op_count, cnt0 + 16'd5);
    end
  endtask

  task automatic test_ops_sweep();
    int cyc;
    for (int s = 4; s <= 7; s++) q0.push_back('{sel: 4'(s), a: 4'b1001, b: 4'd3});
    for (int k = 0; k < 14; k++) q1.push_back('{sel: 4'(k), a: 4'($urandom_range(0, 15)), b: 4'($urandom_range(0, 15))});
    run_queues(300, 1'b0, cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    for (int k = 0; k < 20; k++) begin
      q0.push_back('{sel: 4'($urandom_range(0, 15)), a: 4'($urandom_range(0, 15)), b: 4'($urandom_range(0, 15))});
      q1.push_back('{sel: 4'($urandom_range(0, 15)), a: 4'($urandom_range(0, 15)), b: 4'($urandom_range(0, 15))});
    end
    run_queues(2000, 1'b1, cyc);
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_sel   = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    acc           = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_errors();
    test_ops_sweep();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
